// File: rtl/locker_users.sv
// -----------------------------------------------------------------------------
// locker_users
//   Multi-user password checker for the digital locker. Four 12-bit passwords
//   are fixed at elaboration; User selects which one an attempt is compared
//   against. A rising edge on Enter is one attempt. A correct attempt opens
//   the locker. Consecutive wrong attempts are counted across all users. When
//   the count reaches MAX_TRIES, the block latches Alarm and ignores every
//   further attempt until Reset.
//
// Ports
//   Clk     in   1   system clock, all state changes on its rising edge
//   Reset   in   1   synchronous active-high reset
//   User    in   2   user select, sampled at the attempt edge
//   PassIn  in  12   entered password, sampled at the attempt edge
//   Enter   in   1   attempt strobe (only its 0->1 transition counts)
//   Access  out  1   registered, high while the last evaluated attempt matched
//   Count   out  2   registered consecutive-failure count, saturates at MAX_TRIES
//   Alarm   out  1   registered, high once lockout has occurred
// -----------------------------------------------------------------------------
module locker_users #(
    parameter logic [11:0] PASS0     = 12'h3C5,
    parameter logic [11:0] PASS1     = 12'hF2A,
    parameter logic [11:0] PASS2     = 12'h7B1,
    parameter logic [11:0] PASS3     = 12'hD46,
    parameter int unsigned MAX_TRIES = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  User,
    input  logic [11:0] PassIn,
    input  logic        Enter,
    output logic        Access,
    output logic [1:0]  Count,
    output logic        Alarm
);

    // Legal MAX_TRIES range is 1..3, so it always fits the 2-bit Count.
    localparam logic [1:0] MAX_TRIES_C = 2'(MAX_TRIES);

    typedef enum logic [1:0] {
        ST_LOCKED = 2'd0,
        ST_OPEN   = 2'd1,
        ST_ALARM  = 2'd2
    } state_t;

    state_t      state_r;
    logic        enter_q;
    logic        attempt_s;
    logic [11:0] expected_s;
    logic        match_s;
    logic [1:0]  fail_cnt_s;

    // Attempt detection, password selection and the failure count a mismatch would produce.
    always_comb begin
        attempt_s  = Enter & ~enter_q;
        expected_s = 12'h000;
        case (User)
            2'd0:    expected_s = PASS0;
            2'd1:    expected_s = PASS1;
            2'd2:    expected_s = PASS2;
            2'd3:    expected_s = PASS3;
            default: expected_s = PASS0;
        endcase
        match_s = (PassIn == expected_s);
        // Leaving OPEN always restarts the count at one. In LOCKED the count is
        // still below MAX_TRIES, so the increment cannot wrap.
        if (state_r == ST_OPEN) begin
            fail_cnt_s = 2'd1;
        end else begin
            fail_cnt_s = Count + 2'd1;
        end
    end

    // Lock state machine with registered outputs and the Enter history flop.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_LOCKED;
            enter_q <= 1'b0;
            Access  <= 1'b0;
            Count   <= 2'd0;
            Alarm   <= 1'b0;
        end else begin
            enter_q <= Enter;
            if (attempt_s) begin
                case (state_r)
                    ST_LOCKED, ST_OPEN: begin
                        if (match_s) begin
                            state_r <= ST_OPEN;
                            Access  <= 1'b1;
                            Count   <= 2'd0;
                        end else if (fail_cnt_s == MAX_TRIES_C) begin
                            state_r <= ST_ALARM;
                            Access  <= 1'b0;
                            Count   <= fail_cnt_s;
                            Alarm   <= 1'b1;
                        end else begin
                            state_r <= ST_LOCKED;
                            Access  <= 1'b0;
                            Count   <= fail_cnt_s;
                        end
                    end
                    ST_ALARM: begin
                        // Lockout: every attempt is ignored until Reset.
                        state_r <= ST_ALARM;
                    end
                    default: begin
                        // An unreachable encoding falls back to the safe closed state.
                        state_r <= ST_LOCKED;
                        Access  <= 1'b0;
                        Count   <= 2'd0;
                        Alarm   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_locker_users.sv
module tb_locker_users;

    logic        Clk;
    logic        Reset;
    logic [1:0]  User;
    logic [11:0] PassIn;
    logic        Enter;
    logic        Access;
    logic [1:0]  Count;
    logic        Alarm;

    int vectors;
    int miscompares;

    locker_users dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .User   (User),
        .PassIn (PassIn),
        .Enter  (Enter),
        .Access (Access),
        .Count  (Count),
        .Alarm  (Alarm)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Compare all three outputs against hand-computed values.
    task automatic check(input string tag, input logic exp_access,
                         input logic [1:0] exp_count, input logic exp_alarm);
        vectors++;
        assert (Access === exp_access) else begin
            miscompares++;
            $error("FAIL %s Access: observed %b expected %b", tag, Access, exp_access);
        end
        vectors++;
        assert (Count === exp_count) else begin
            miscompares++;
            $error("FAIL %s Count: observed %0d expected %0d", tag, Count, exp_count);
        end
        vectors++;
        assert (Alarm === exp_alarm) else begin
            miscompares++;
            $error("FAIL %s Alarm: observed %b expected %b", tag, Alarm, exp_alarm);
        end
    endtask

    // One Enter pulse spanning one rising edge; ends at a falling edge with Enter low.
    task automatic attempt(input logic [1:0] u, input logic [11:0] p);
        @(negedge Clk);
        User   = u;
        PassIn = p;
        Enter  = 1'b1;
        @(negedge Clk);
        Enter  = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset  = 1'b1;
        User   = 2'd0;
        PassIn = 12'h000;
        Enter  = 1'b0;

        repeat (2) @(negedge Clk);
        check("reset", 1'b0, 2'd0, 1'b0);
        Reset = 1'b0;

        // Grant access
        attempt(2'd1, 12'hF2A);  check("grant_u1",   1'b1, 2'd0, 1'b0);

        // Lockout sequence
        attempt(2'd1, 12'h0AA);  check("fail1_0AA",  1'b0, 2'd1, 1'b0);
        attempt(2'd1, 12'h999);  check("fail2_999",  1'b0, 2'd2, 1'b0);
        attempt(2'd1, 12'h123);  check("fail3_alarm", 1'b0, 2'd3, 1'b1);

        // Lockout holds, even for a correct password
        attempt(2'd1, 12'h007);  check("alarm_007",  1'b0, 2'd3, 1'b1);
        attempt(2'd1, 12'hF2A);  check("alarm_good", 1'b0, 2'd3, 1'b1);

        // Recovery after a one-cycle reset
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("reset_alarm", 1'b0, 2'd0, 1'b0);
        Reset = 1'b0;
        attempt(2'd1, 12'h567);  check("rec_fail",   1'b0, 2'd1, 1'b0);
        attempt(2'd1, 12'hF2A);  check("rec_grant",  1'b1, 2'd0, 1'b0);

        // Per-user passwords: user 1's password is wrong for user 2
        attempt(2'd2, 12'hF2A);  check("u2_wrong",   1'b0, 2'd1, 1'b0);
        attempt(2'd2, 12'h7B1);  check("u2_grant",   1'b1, 2'd0, 1'b0);

        // The failure count is shared: switching user does not clear it
        attempt(2'd0, 12'h111);  check("u0_fail",    1'b0, 2'd1, 1'b0);
        attempt(2'd3, 12'h222);  check("u3_fail",    1'b0, 2'd2, 1'b0);
        attempt(2'd3, 12'hD46);  check("u3_grant",   1'b1, 2'd0, 1'b0);
        attempt(2'd0, 12'h3C5);  check("u0_grant",   1'b1, 2'd0, 1'b0);

        // Enter held for 5 edges with a wrong password counts once
        @(negedge Clk);
        User   = 2'd0;
        PassIn = 12'h000;
        Enter  = 1'b1;
        @(negedge Clk);
        check("hold_first", 1'b0, 2'd1, 1'b0);
        repeat (4) @(negedge Clk);
        check("hold_five",  1'b0, 2'd1, 1'b0);
        Enter = 1'b0;

        // Input changes without an attempt have no effect
        @(negedge Clk);
        PassIn = 12'h3C5;
        User   = 2'd0;
        repeat (3) @(negedge Clk);
        check("idle_change", 1'b0, 2'd1, 1'b0);

        // Reset on the same edge as a correct attempt: the attempt is discarded
        Reset = 1'b1;
        Enter = 1'b1;
        @(negedge Clk);
        check("reset_vs_attempt", 1'b0, 2'd0, 1'b0);

        // Enter still high at the first edge after reset counts as an attempt
        Reset = 1'b0;
        @(negedge Clk);
        check("enter_after_reset", 1'b1, 2'd0, 1'b0);
        Enter = 1'b0;

        // Idle: outputs hold
        repeat (3) @(negedge Clk);
        check("idle_hold", 1'b1, 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
